// File: rtl/seq_bit_serializer_pkg.sv
// Shared FSM encodings, counter widths and default geometry for the serializer
// that feeds the 10101 sequence detector.
package seq_bit_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_GAP     = 0;
    localparam int GAP_CNT_W   = 4;
    localparam int FRAME_CNT_W = 8;

    typedef logic [GAP_CNT_W-1:0]   gap_cnt_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Word-load handshake between the pattern source (master) and the serializer (slave).
interface seq_bit_serializer_if
    import seq_bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;

    modport master (output load_data, output load_valid, input load_ready);
    modport slave  (input load_data, input load_valid, output load_ready);

endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 10101 detector: one bit per fsm_clk, optional
// forced-zero gap between frames, and a loop mode that replays the captured word.
module seq_bit_serializer
    import seq_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int GAP       = DEF_GAP,
    parameter int MSB_FIRST = 1
) (
    input  logic                     fsm_clk,
    input  logic                     rst,
    seq_bit_serializer_if.slave      load,
    input  logic                     loop_en,
    output logic                     ser_out,
    output logic                     bit_valid,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     busy,
    output logic                     frame_done,
    output frame_cnt_t               frame_cnt
);

    localparam int                 IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(WIDTH - 1);
    localparam bit                 HAS_GAP  = (GAP > 0);
    localparam gap_cnt_t           GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] saved;
    gap_cnt_t         gap_cnt;

    logic last_bit;
    logic last_gap;
    logic head_bit;

    assign last_bit = (state == ST_SHIFT) && (bit_idx == IDX_LAST);
    assign last_gap = (state == ST_GAP) && (gap_cnt == GAP_LAST);
    assign head_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    // Outputs decode state registers only; loop_en gates ready so a looping
    // frame never advertises room for a word it would ignore.
    assign bit_valid       = (state == ST_SHIFT);
    assign ser_out         = bit_valid & head_bit;
    assign busy            = (state != ST_IDLE);
    assign frame_done      = last_bit;
    assign load.load_ready = (state == ST_IDLE)
                           | (last_bit & !HAS_GAP & !loop_en)
                           | (last_gap & !loop_en);

    // NOTE: state registers use non-blocking assignments so every branch below
    // sees the pre-edge values, matching the hardware behaviour of flip-flops.
    always_ff @(posedge fsm_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            saved     <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_idx <= '0;
                    if (load.load_valid) begin
                        shreg <= load.load_data;
                        saved <= load.load_data;
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (last_bit) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        bit_idx   <= '0;
                        if (HAS_GAP) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else if (loop_en) begin
                            shreg <= saved;
                        end else if (load.load_valid) begin
                            shreg <= load.load_data;
                            saved <= load.load_data;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        shreg   <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                        bit_idx <= bit_idx + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (last_gap) begin
                        gap_cnt <= '0;
                        if (loop_en) begin
                            shreg <= saved;
                            state <= ST_SHIFT;
                        end else if (load.load_valid) begin
                            shreg <= load.load_data;
                            saved <= load.load_data;
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    bit_idx <= '0;
                    gap_cnt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
